// File: rtl/xspi_crc_pkg.sv
// Shared definitions for the xSPI 8S CRC receive path: CRC-8 constants,
// controller state encoding and the byte-wise CRC update.
package xspi_crc_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DISCARD,
        CHECK,
        DRAIN
    } state_t;

    // MSB-first, non-reflected CRC-8 over one byte.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        // NOTE: blocking assignments are correct here; the function describes
        // a single combinational chain of eight shift/XOR steps.
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/xspi_crc_rx_buf.sv
// Payload staging buffer: MAX_LEN bytes written in order, read back in order,
// cleared by resetting both pointers.
module xspi_crc_rx_buf #(
    parameter int MAX_LEN = 16,
    localparam int PW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_adv,
    output logic [7:0]    rd_data,
    output logic          rd_last,
    output logic [PW-1:0] len,
    output logic          full
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [7:0]    mem [MAX_LEN];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // NOTE: the storage array has no reset; the pointers alone decide which
    // entries are meaningful, so clearing them is enough.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) wr_ptr <= wr_ptr + PW'(1);
            if (rd_adv)         rd_ptr <= rd_ptr + PW'(1);
        end
    end

    assign len     = wr_ptr;
    assign full    = (wr_ptr == PW'(MAX_LEN));
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign rd_last = ((rd_ptr + PW'(1)) == wr_ptr);

endmodule

// File: rtl/xspi_crc_rx_ctrl.sv
// Receive controller: buffers a frame, checks its trailing CRC-8 byte, then
// either releases the payload or requests retransmission / aborts.
module xspi_crc_rx_ctrl
    import xspi_crc_pkg::*;
#(
    parameter int MAX_LEN   = 16,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255,
    localparam int RW = $clog2(MAX_RETRY + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          rx_last,
    output logic          rx_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          frame_ok,
    output logic          frame_err,
    output logic          retx_req,
    output logic          abort,
    output logic [RW-1:0] retry_cnt,
    output logic [7:0]    crc_calc
);

    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [7:0]    crc;
    logic          match_q;
    logic [TW-1:0] idle_cnt;

    logic          rx_fire, out_fire, close, crc_match, discard_end, timeout_hit, fail_evt;
    logic          wr_en, buf_clr, full, rd_last;
    logic [7:0]    rd_data;
    logic [PW-1:0] len;

    // rx_ready is decoded from the state register; gating with rst holds it low
    // for the whole reset interval even though the state already reads IDLE.
    assign rx_ready  = !rst && (state == IDLE || state == RECV || state == DISCARD);
    assign rx_fire   = rx_valid && rx_ready;
    assign out_valid = (state == DRAIN);
    assign out_fire  = out_valid && out_ready;
    assign out_data  = out_valid ? rd_data : 8'h00;
    assign out_last  = out_valid && rd_last;
    assign crc_calc  = crc;

    assign close       = rx_fire && rx_last && (state == IDLE || state == RECV);
    assign crc_match   = (rx_data == crc);
    assign discard_end = rx_fire && rx_last && (state == DISCARD);
    assign timeout_hit = (state == RECV || state == DISCARD) && !rx_valid
                         && (idle_cnt == TW'(TIMEOUT - 1));
    assign fail_evt    = (close && !crc_match) || discard_end || timeout_hit;

    assign wr_en   = rx_fire && !rx_last && (state == IDLE || state == RECV);
    assign buf_clr = discard_end || timeout_hit || (out_fire && rd_last)
                     || (state == CHECK && !(match_q && len != '0));

    xspi_crc_rx_buf #(.MAX_LEN(MAX_LEN)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (wr_en),
        .wr_data (rx_data),
        .rd_adv  (out_fire),
        .rd_data (rd_data),
        .rd_last (rd_last),
        .len     (len),
        .full    (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            crc       <= CRC8_INIT;
            match_q   <= 1'b0;
            idle_cnt  <= '0;
            retry_cnt <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            retx_req  <= 1'b0;
            abort     <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            retx_req  <= 1'b0;
            abort     <= 1'b0;

            case (state)
                IDLE: if (rx_fire) begin
                    state <= rx_last ? CHECK : RECV;
                    if (!rx_last) crc <= crc8_byte(crc, rx_data);
                end
                RECV: if (rx_fire) begin
                    if (rx_last)   state <= CHECK;
                    else if (full) state <= DISCARD;
                    else           crc   <= crc8_byte(crc, rx_data);
                end else if (timeout_hit) begin
                    state <= IDLE;
                    crc   <= CRC8_INIT;
                end
                DISCARD: if (discard_end || timeout_hit) begin
                    state <= IDLE;
                    crc   <= CRC8_INIT;
                end
                CHECK: if (match_q && len != '0) begin
                    state <= DRAIN;
                end else begin
                    state <= IDLE;
                    crc   <= CRC8_INIT;
                end
                DRAIN: if (out_fire && rd_last) begin
                    state <= IDLE;
                    crc   <= CRC8_INIT;
                end
                default: state <= IDLE;
            endcase

            if ((state == RECV || state == DISCARD) && !rx_valid) idle_cnt <= idle_cnt + TW'(1);
            else                                                  idle_cnt <= '0;

            // The verdict is known on the edge that takes the CRC byte, so the
            // status pulses land in the CHECK cycle.
            if (close) match_q <= crc_match;
            if (close && crc_match) begin
                frame_ok  <= 1'b1;
                retry_cnt <= '0;
            end
            if (fail_evt) begin
                frame_err <= 1'b1;
                if (int'(retry_cnt) + 1 < MAX_RETRY) begin
                    retx_req  <= 1'b1;
                    retry_cnt <= retry_cnt + RW'(1);
                end else begin
                    abort     <= 1'b1;
                    retry_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_xspi_crc_rx_ctrl.sv
// Directed bench for xspi_crc_rx_ctrl with hand-computed CRC-8 expectations.
module tb_xspi_crc_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid, rx_last, out_ready;
    logic [7:0] rx_data;
    logic       rx_ready, out_valid, out_last;
    logic [7:0] out_data, crc_calc;
    logic       frame_ok, frame_err, retx_req, abort;
    logic [1:0] retry_cnt;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc;
    int         seen;
    logic [7:0] exp_q [0:15];

    always #5 clk = ~clk;

    xspi_crc_rx_ctrl #(.MAX_LEN(16), .MAX_RETRY(3), .TIMEOUT(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_last   (rx_last),
        .rx_ready  (rx_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .retx_req  (retx_req),
        .abort     (abort),
        .retry_cnt (retry_cnt),
        .crc_calc  (crc_calc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Presents one byte from a negedge, waits for rx_ready (bounded), returns
    // at the negedge after the accepting edge with rx_valid dropped.
    task automatic rx_byte(input logic [7:0] d, input logic last);
        int g = 0;
        rx_valid = 1'b1;
        rx_data  = d;
        rx_last  = last;
        while (!rx_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("rx_ready_wait", rx_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    // Consumes output bytes against exp_q until 'stop' bytes have transferred.
    task automatic drain(input int total, input bit toggle, input int stop, output int cycles);
        int idx = 0;
        int c = 0;
        while (idx < stop && c < 200) begin
            out_ready = toggle ? c[0] : 1'b1;
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, exp_q[idx]);
            chk("drain_last", out_last, (idx == total - 1));
            if (out_ready) idx++;
            @(negedge clk);
            c++;
        end
        chk("drain_count", idx, stop);
        out_ready = 1'b1;
        cycles = c;
    endtask

    task automatic bad_frame(input logic [1:0] exp_retry, input bit exp_abort);
        rx_byte(8'h01, 1'b0);
        rx_byte(8'h00, 1'b1);
        chk("bad_frame_err", frame_err, 1);
        chk("bad_retx", retx_req, !exp_abort);
        chk("bad_abort", abort, exp_abort);
        chk("bad_ok", frame_ok, 0);
        chk("bad_retry", retry_cnt, exp_retry);
        chk("bad_no_out", out_valid, 0);
        @(negedge clk);
        chk("bad_no_out2", out_valid, 0);
        chk("bad_pulse_width", frame_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0; out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pulses", {frame_ok, frame_err, retx_req, abort}, 4'b0000);
        chk("rst_retry", retry_cnt, 0);
        chk("rst_crc", crc_calc, 8'h00);
        rst = 1'b0;
        #1;
        chk("rel_rx_ready", rx_ready, 1);
        @(negedge clk);

        // Good frame 0x31..0x39, CRC 0xF4, full-rate drain
        for (int i = 0; i < 9; i++) exp_q[i] = 8'(8'h31 + i);
        for (int i = 0; i < 9; i++) rx_byte(exp_q[i], 1'b0);
        chk("crc_running", crc_calc, 8'hF4);
        rx_byte(8'hF4, 1'b1);
        chk("good_ok", frame_ok, 1);
        chk("good_err", frame_err, 0);
        chk("check_rx_ready", rx_ready, 0);
        chk("check_crc_hold", crc_calc, 8'hF4);
        chk("check_no_out", out_valid, 0);
        @(negedge clk);
        chk("ok_pulse_width", frame_ok, 0);
        chk("first_valid", out_valid, 1);
        chk("drain_rx_ready", rx_ready, 0);
        drain(9, 1'b0, 9, cyc);
        chk("drain_cycles", cyc, 9);
        chk("after_drain_valid", out_valid, 0);
        chk("after_drain_ready", rx_ready, 1);
        chk("after_drain_crc", crc_calc, 8'h00);
        chk("good_retry", retry_cnt, 0);

        // Bad CRC then corrected resend
        bad_frame(2'd1, 1'b0);
        exp_q[0] = 8'h01;
        rx_byte(8'h01, 1'b0);
        rx_byte(8'h07, 1'b1);
        chk("resend_ok", frame_ok, 1);
        chk("resend_retry", retry_cnt, 0);
        @(negedge clk);
        drain(1, 1'b0, 1, cyc);

        // Three consecutive failures: retx, retx, abort
        bad_frame(2'd1, 1'b0);
        bad_frame(2'd2, 1'b0);
        bad_frame(2'd0, 1'b1);

        // Zero-length frame
        rx_byte(8'h00, 1'b1);
        chk("zl_ok", frame_ok, 1);
        chk("zl_rx_ready", rx_ready, 0);
        chk("zl_no_out", out_valid, 0);
        @(negedge clk);
        chk("zl_idle", rx_ready, 1);
        chk("zl_no_out2", out_valid, 0);

        // Overflow: 17 payload bytes then the CRC byte
        for (int i = 0; i < 17; i++) rx_byte(8'(i), 1'b0);
        chk("ovf_still_ready", rx_ready, 1);
        rx_byte(8'h00, 1'b1);
        chk("ovf_err", frame_err, 1);
        chk("ovf_retx", retx_req, 1);
        chk("ovf_ok", frame_ok, 0);
        chk("ovf_retry", retry_cnt, 1);
        chk("ovf_to_idle", rx_ready, 1);
        chk("ovf_no_out", out_valid, 0);
        @(negedge clk);
        chk("ovf_no_out2", out_valid, 0);

        // Timeout: 254 idle cycles are tolerated, the 255th fails the frame
        rx_byte(8'hAA, 1'b0);
        repeat (254) @(negedge clk);
        chk("to_not_yet", frame_err, 0);
        @(negedge clk);
        chk("to_err", frame_err, 1);
        chk("to_retx", retx_req, 1);
        chk("to_retry", retry_cnt, 2);
        chk("to_idle", rx_ready, 1);

        // A good frame clears the failure count
        rx_byte(8'h01, 1'b0);
        rx_byte(8'h07, 1'b1);
        chk("clear_ok", frame_ok, 1);
        chk("clear_retry", retry_cnt, 0);
        @(negedge clk);
        drain(1, 1'b0, 1, cyc);

        // Drain with out_ready toggling every cycle
        for (int i = 0; i < 9; i++) exp_q[i] = 8'(8'h31 + i);
        for (int i = 0; i < 9; i++) rx_byte(exp_q[i], 1'b0);
        rx_byte(8'hF4, 1'b1);
        chk("tog_ok", frame_ok, 1);
        @(negedge clk);
        drain(9, 1'b1, 9, cyc);
        chk("tog_done", out_valid, 0);

        // Reset while the 4th byte is on the output
        for (int i = 0; i < 9; i++) rx_byte(exp_q[i], 1'b0);
        rx_byte(8'hF4, 1'b1);
        @(negedge clk);
        drain(9, 1'b1, 3, cyc);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data", out_data, 8'h34);
        chk("pre_rst_crc", crc_calc, 8'hF4);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 8'h00);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_ready", rx_ready, 0);
        chk("mid_rst_crc", crc_calc, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("post_rst_no_out", seen, 0);
        chk("post_rst_ready", rx_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xspi_crc_rx_ctrl.md
# xspi_crc_rx_ctrl

Slave-side receive controller for the xSPI 8S CRC retransmission path. Accepts a byte stream where each frame is payload bytes followed by one CRC-8 byte, and buffers the payload while computing CRC-8. Releases the payload downstream only if the CRC matches. On a mismatch it discards the frame and requests retransmission. After a bounded number of consecutive failures it aborts.

## Interface
Parameters:
- MAX_LEN, 16: maximum payload bytes per frame; sets buffer depth.
- MAX_RETRY, 3: number of consecutive failed frames that triggers abort.
- TIMEOUT, 255: idle cycles allowed mid-frame before the frame is declared failed.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rx_valid  in  1  rx_data is valid.
- rx_data  in  8  received byte.
- rx_last  in  1  qualifies the CRC byte that closes the frame.
- rx_ready  out  1  controller can accept a byte.
- out_valid  out  1  verified payload byte available.
- out_data  out  8  payload byte.
- out_last  out  1  final payload byte of the frame.
- out_ready  in  1  downstream accepts out_data.
- frame_ok  out  1  one-cycle pulse: CRC matched.
- frame_err  out  1  one-cycle pulse: frame failed (CRC mismatch, overflow or timeout).
- retx_req  out  1  one-cycle pulse: retransmission requested.
- abort  out  1  one-cycle pulse: retry budget exhausted.
- retry_cnt  out  $clog2(MAX_RETRY+1)  consecutive failure count.
- crc_calc  out  8  running CRC; holds its last value through CHECK.

## Operation
- CRC: poly 0x07, init 0x00, MSB-first, no reflection, no final XOR. CRC of 0x31..0x39 is 0xF4.
- A byte transfers on a rising edge with rx_valid && rx_ready. The same rule applies to out_valid && out_ready.
- States:
  - IDLE: rx_ready=1 and the CRC is cleared. Accepting a non-last byte stores it, updates the CRC and moves to RECV. Accepting a last byte moves to CHECK as a zero-length frame.
  - RECV: rx_ready=1. Each non-last byte is written at wr_ptr, wr_ptr increments and the CRC updates. A last byte latches the received CRC and moves to CHECK. The (MAX_LEN+1)th non-last byte moves to DISCARD.
  - DISCARD: rx_ready=1. Bytes are accepted and dropped until rx_last. Then the controller runs the failure path without entering CHECK.
  - CHECK: lasts one cycle with rx_ready=0. On a match: pulse frame_ok, clear retry_cnt, then go to DRAIN if length>0 or IDLE if length is 0. On a mismatch: run the failure path.
  - DRAIN: rx_ready=0. Presents buffer[0..len-1] in order with out_last on the final byte. Returns to IDLE after the final transfer.
- Failure path: pulse frame_err and increment retry_cnt.
  - If the new count is below MAX_RETRY, also pulse retx_req.
  - Otherwise pulse abort, not retx_req, and clear retry_cnt.
  - Clear the buffer and go to IDLE.
- Timeout: in RECV or DISCARD, TIMEOUT consecutive cycles with rx_valid=0 trigger the failure path. The idle counter resets on every accepted byte.
- out_data and out_last hold stable while out_valid=1 && out_ready=0.

## Timing
- Reset values: rx_ready=0 while rst is high and 1 in the first cycle after release (IDLE). All other outputs, wr_ptr, the buffer pointers and the state are 0/IDLE.
- Status pulses are registered. They are high for exactly one cycle, the cycle after the edge that accepted the CRC byte (or the timeout edge).
- CRC byte accepted at edge N: CHECK occupies the cycle after edge N. The first out_valid appears the cycle after edge N+1, so CRC byte to first payload byte is 2 cycles.
- Drain throughput is 1 byte/cycle while out_ready=1.
- No new rx byte is accepted from CHECK until the cycle after the final out_last transfer.
- Asserting rst mid-frame or mid-drain drops all state immediately. The partial frame is lost and nothing is emitted afterwards.
- frame_err and retx_req coincide. frame_err and abort coincide. retx_req and abort are never both high.

## Structure
- Package xspi_crc_pkg holds:
  - CRC8_POLY = 8'h07 and CRC8_INIT = 8'h00.
  - The state enum (IDLE, RECV, DISCARD, CHECK, DRAIN).
  - A pure function crc8_byte(crc, data) that performs eight shift/XOR steps.
- One sub-module is natural: xspi_crc_rx_buf, a MAX_LEN x 8 register buffer with write pointer, read pointer, length and clear.

## Test plan
- Payload 0x31..0x39, CRC 0xF4: frame_ok, 9 bytes out in order with out_last on 0x39, retry_cnt=0.
- Payload 0x01, CRC 0x00 (correct value 0x07): frame_err and retx_req, retry_cnt=1, no out_valid. Resend with CRC 0x07: frame_ok, output 0x01 with out_last, retry_cnt=0.
- Three consecutive bad frames with MAX_RETRY=3: retx_req on the 1st and 2nd. The 3rd gives abort with no retx_req and retry_cnt back to 0.
- Zero-length frame (single byte 0x00 with rx_last): frame_ok, out_valid never asserts, back in IDLE after 2 cycles.
- 17 payload bytes then a CRC byte with MAX_LEN=16: all bytes accepted, frame_err and retx_req after rx_last, no output. Separately, stall rx_valid for 255 cycles mid-frame: frame_err on timeout.
- Drain 0x31..0x39 with out_ready toggling every cycle: data is held stable during stalls and nothing is lost. Assert rst at the 4th output byte: all outputs go to 0 and no further output appears.
